// File: rtl/adder_bist_if.sv
// Operand/response bus between the adder BIST engine and the combinational adder under test.
interface adder_bist_if #(
    parameter int N = 8
) ();
    logic [N-1:0] a_o;
    logic [N-1:0] b_o;
    logic         cin_o;
    logic [N-1:0] s_i;
    logic         cout_i;
    logic         prop_i;
    logic         gen_i;

    modport master (output a_o, b_o, cin_o, input s_i, cout_i, prop_i, gen_i);
    modport slave  (input a_o, b_o, cin_o, output s_i, cout_i, prop_i, gen_i);
endinterface

// File: rtl/adder_bist.sv
// Self-test engine for the adder family: walks exhaustive or LFSR vectors through an external
// combinational adder, checks against a behavioural reference, counts errors, captures the first failure.
module adder_bist #(
    parameter int          N       = 8,
    parameter int          NUM_VEC = 30000,
    parameter int          CNT_W   = 17,
    parameter int          ERR_W   = 16,
    parameter logic [31:0] SEED    = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             check_pg,
    adder_bist_if.master     duv,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [N-1:0]     fail_a,
    output logic [N-1:0]     fail_b,
    output logic             fail_cin
);
    localparam int               VW    = 2 * N + 1;
    localparam longint           SPACE = 64'd1 << VW;
    localparam longint           T     = (longint'(NUM_VEC) < SPACE) ? longint'(NUM_VEC) : SPACE;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(T - 1);
    localparam logic [31:0]      TAPS  = 32'h8020_0003;   // x^32 + x^22 + x^2 + x + 1

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] vec;
    logic        mode_q;
    logic        pg_q;

    logic [N-1:0]     cur_a, cur_b;
    logic             cur_cin;
    logic [N:0]       ref_sum, ref_ab;
    logic             ref_prop;
    logic             mismatch;
    logic [ERR_W-1:0] err_nxt;
    logic [31:0]      lfsr_nxt;

    // V = {cin, a, b}; the operand bus is driven straight from the vector flop.
    assign cur_b   = vec[N-1:0];
    assign cur_a   = vec[2*N-1:N];
    assign cur_cin = vec[2*N];

    assign duv.a_o   = cur_a;
    assign duv.b_o   = cur_b;
    assign duv.cin_o = cur_cin;

    assign ref_sum  = {1'b0, cur_a} + {1'b0, cur_b} + {{N{1'b0}}, cur_cin};
    assign ref_ab   = {1'b0, cur_a} + {1'b0, cur_b};
    assign ref_prop = &(cur_a ^ cur_b);

    assign mismatch = (duv.s_i != ref_sum[N-1:0]) || (duv.cout_i != ref_sum[N]) ||
                      (pg_q && ((duv.prop_i != ref_prop) || (duv.gen_i != ref_ab[N])));

    assign err_nxt  = (mismatch && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;
    assign lfsr_nxt = vec[0] ? ((vec >> 1) ^ TAPS) : (vec >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            mode_q     <= 1'b0;
            pg_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_cnt    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        vec_cnt    <= '0;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_cin   <= 1'b0;
                        mode_q     <= mode;
                        pg_q       <= check_pg;
                        vec        <= mode ? SEED : 32'd0;
                    end
                end
                RUN: begin
                    vec_cnt <= vec_cnt + CNT_W'(1);
                    err_cnt <= err_nxt;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= cur_a;
                        fail_b     <= cur_b;
                        fail_cin   <= cur_cin;
                    end
                    // The vector is frozen on the final edge so DONE shows the last one checked.
                    if (vec_cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        vec <= mode_q ? lfsr_nxt : vec + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: three engines (N=4 exhaustive, N=8 random/pg, N=8 narrow error counter)
// against a fault-injectable adder; operand sequences are scoreboarded from an independent model.
module tb_adder_bist;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] TAPS = 32'h8020_0003;

    int checks = 0;
    int errors = 0;

    logic [2:0]        start = '0, mode = '0, pg = '0;
    logic [2:0]        busy, done, pass, fv, fc, cin_o;
    logic [2:0][16:0]  vc;
    logic [2:0][15:0]  ec;
    logic [2:0][7:0]   ao, bo, fa, fb;
    int                fault [3] = '{0, 0, 0};

    logic [3:0] ec2;
    logic [3:0] fa0, fb0;
    logic [10:0] r0, r1, r2;

    adder_bist_if #(.N(4)) if0 ();
    adder_bist_if #(.N(8)) if1 ();
    adder_bist_if #(.N(8)) if2 ();

    // Adder under test with optional planted faults: 1 s[0] stuck-0, 2 cout inverted, 3 gen inverted.
    function automatic logic [10:0] duv_model(input int n, input logic [7:0] a, input logic [7:0] b,
                                              input logic c, input int f);
        logic [8:0] full, ab;
        logic [7:0] mask, s;
        logic       co, p, g;
        mask = 8'((1 << n) - 1);
        full = {1'b0, a} + {1'b0, b} + {8'b0, c};
        ab   = {1'b0, a} + {1'b0, b};
        s    = full[7:0] & mask;
        co   = full[n];
        p    = &((a ^ b) | ~mask);
        g    = ab[n];
        if (f == 1) s[0] = 1'b0;
        if (f == 2) co = ~co;
        if (f == 3) g = ~g;
        return {g, p, co, s};
    endfunction

    assign r0 = duv_model(4, {4'b0, if0.a_o}, {4'b0, if0.b_o}, if0.cin_o, fault[0]);
    assign r1 = duv_model(8, if1.a_o, if1.b_o, if1.cin_o, fault[1]);
    assign r2 = duv_model(8, if2.a_o, if2.b_o, if2.cin_o, fault[2]);
    assign if0.s_i = r0[3:0];
    assign if1.s_i = r1[7:0];
    assign if2.s_i = r2[7:0];
    assign {if0.gen_i, if0.prop_i, if0.cout_i} = r0[10:8];
    assign {if1.gen_i, if1.prop_i, if1.cout_i} = r1[10:8];
    assign {if2.gen_i, if2.prop_i, if2.cout_i} = r2[10:8];

    assign ao[0] = {4'b0, if0.a_o};
    assign bo[0] = {4'b0, if0.b_o};
    assign ao[1] = if1.a_o;
    assign bo[1] = if1.b_o;
    assign ao[2] = if2.a_o;
    assign bo[2] = if2.b_o;
    assign cin_o = {if2.cin_o, if1.cin_o, if0.cin_o};
    assign ec[2] = {12'b0, ec2};
    assign fa[0] = {4'b0, fa0};
    assign fb[0] = {4'b0, fb0};

    adder_bist #(.N(4), .NUM_VEC(1000), .CNT_W(17), .ERR_W(16), .SEED(32'h1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]), .check_pg(pg[0]),
        .duv(if0.master), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .vec_cnt(vc[0]),
        .err_cnt(ec[0]), .fail_valid(fv[0]), .fail_a(fa0), .fail_b(fb0), .fail_cin(fc[0]));

    adder_bist #(.N(8), .NUM_VEC(2000), .CNT_W(17), .ERR_W(16), .SEED(32'h1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]), .check_pg(pg[1]),
        .duv(if1.master), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .vec_cnt(vc[1]),
        .err_cnt(ec[1]), .fail_valid(fv[1]), .fail_a(fa[1]), .fail_b(fb[1]), .fail_cin(fc[1]));

    adder_bist #(.N(8), .NUM_VEC(100), .CNT_W(17), .ERR_W(4), .SEED(32'h1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode[2]), .check_pg(pg[2]),
        .duv(if2.master), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .vec_cnt(vc[2]),
        .err_cnt(ec2), .fail_valid(fv[2]), .fail_a(fa[2]), .fail_b(fb[2]), .fail_cin(fc[2]));

    function automatic int nbits(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int tval(input int d);
        return (d == 0) ? 512 : (d == 1) ? 2000 : 100;
    endfunction

    // Push the whole expected operand stream, start the engine, then pop/compare one vector per RUN cycle.
    task automatic run(input int d, input logic m, input logic p, input int pulse_at,
                       output int cyc, output int bad, output logic [31:0] last);
        int          n, t;
        int          q[$];
        logic [31:0] v, e, got, vmask, omask;
        n     = nbits(d);
        t     = tval(d);
        vmask = 32'((64'd1 << (2 * n + 1)) - 1);
        omask = 32'((1 << n) - 1);
        v     = m ? 32'h1 : 32'h0;
        for (int i = 0; i < t; i++) begin
            q.push_back(int'(v & vmask));
            v = m ? ((v >> 1) ^ (v[0] ? TAPS : 32'h0)) : v + 32'd1;
        end
        last = 32'(q[$]);
        @(negedge clk);
        start[d] = 1'b1; mode[d] = m; pg[d] = p;
        @(negedge clk);
        start[d] = 1'b0;
        checks++;
        if (vc[d] !== 17'd0 || done[d] !== 1'b0) begin
            errors++;
            $display("FAIL start_clear d=%0d got vec_cnt=%0d done=%0b exp 0 0", d, vc[d], done[d]);
        end
        cyc = 0;
        bad = 0;
        while (busy[d] === 1'b1 && cyc < t + 10) begin
            if (q.size() == 0) bad++;
            else begin
                e   = 32'(q.pop_front());
                got = (32'(cin_o[d]) << (2 * n)) | ((32'(ao[d]) & omask) << n) | (32'(bo[d]) & omask);
                if (got != e) bad++;
            end
            cyc++;
            start[d] = (cyc == pulse_at);
            @(negedge clk);
        end
        start[d] = 1'b0;
        bad += q.size();
        got = (32'(cin_o[d]) << (2 * n)) | (32'(ao[d]) << n) | 32'(bo[d]);
        checks++;
        if (got !== last) begin
            errors++;
            $display("FAIL hold_last d=%0d got %0h exp %0h", d, got, last);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, pass, fv} !== 12'b0) begin
            errors++;
            $display("FAIL reset_flags got %0h exp 0", {busy, done, pass, fv});
        end
        checks++;
        if (vc !== '0 || ec !== '0) begin
            errors++;
            $display("FAIL reset_counts got vc=%0h ec=%0h exp 0", vc, ec);
        end
        checks++;
        if (ao !== '0 || bo !== '0 || cin_o !== 3'b0 || fa !== '0 || fb !== '0 || fc !== 3'b0) begin
            errors++;
            $display("FAIL reset_vec got a=%0h b=%0h cin=%0b exp 0", ao, bo, cin_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_exhaustive();
        int cyc, bad; logic [31:0] last;
        run(0, 1'b0, 1'b0, -1, cyc, bad, last);
        checks++;
        if (cyc !== 512) begin errors++; $display("FAIL exh_cycles got %0d exp 512", cyc); end
        checks++;
        if (vc[0] !== 17'd512) begin errors++; $display("FAIL exh_vec_cnt got %0d exp 512", vc[0]); end
        checks++;
        if (ec[0] !== 16'd0 || pass[0] !== 1'b1 || fv[0] !== 1'b0 || done[0] !== 1'b1) begin
            errors++;
            $display("FAIL exh_result got err=%0d pass=%0b fv=%0b done=%0b exp 0 1 0 1", ec[0], pass[0], fv[0], done[0]);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL exh_sequence got %0d bad vectors exp 0", bad); end
    endtask

    task automatic test_stuck_s0();
        int cyc, bad; logic [31:0] last;
        fault[0] = 1;
        run(0, 1'b0, 1'b0, -1, cyc, bad, last);
        fault[0] = 0;
        checks++;
        if (ec[0] !== 16'd256) begin errors++; $display("FAIL s0_err_cnt got %0d exp 256", ec[0]); end
        checks++;
        if (fv[0] !== 1'b1 || fa[0] !== 8'd0 || fb[0] !== 8'd1 || fc[0] !== 1'b0) begin
            errors++;
            $display("FAIL s0_capture got fv=%0b a=%0d b=%0d cin=%0b exp 1 0 1 0", fv[0], fa[0], fb[0], fc[0]);
        end
        checks++;
        if (pass[0] !== 1'b0) begin errors++; $display("FAIL s0_pass got %0b exp 0", pass[0]); end
    endtask

    task automatic test_restart_from_done();
        int cyc, bad; logic [31:0] last;
        run(0, 1'b0, 1'b0, -1, cyc, bad, last);
        checks++;
        if (cyc !== 512 || ec[0] !== 16'd0 || fv[0] !== 1'b0 || pass[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart got cyc=%0d err=%0d fv=%0b pass=%0b exp 512 0 0 1", cyc, ec[0], fv[0], pass[0]);
        end
    endtask

    task automatic test_start_in_run();
        int cyc, bad; logic [31:0] last;
        run(0, 1'b0, 1'b0, 50, cyc, bad, last);
        checks++;
        if (cyc !== 512 || vc[0] !== 17'd512 || bad !== 0) begin
            errors++;
            $display("FAIL start_in_run got cyc=%0d vec_cnt=%0d bad=%0d exp 512 512 0", cyc, vc[0], bad);
        end
    endtask

    task automatic test_random();
        int cyc, bad; logic [31:0] last;
        run(1, 1'b1, 1'b0, -1, cyc, bad, last);
        checks++;
        if (cyc !== 2000 || vc[1] !== 17'd2000) begin
            errors++;
            $display("FAIL rnd_count got cyc=%0d vec_cnt=%0d exp 2000 2000", cyc, vc[1]);
        end
        checks++;
        if (ec[1] !== 16'd0 || pass[1] !== 1'b1) begin
            errors++;
            $display("FAIL rnd_result got err=%0d pass=%0b exp 0 1", ec[1], pass[1]);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rnd_sequence got %0d bad vectors exp 0", bad); end
    endtask

    task automatic test_pg();
        int cyc, bad; logic [31:0] last;
        fault[1] = 3;
        run(1, 1'b0, 1'b0, -1, cyc, bad, last);
        checks++;
        if (ec[1] !== 16'd0) begin errors++; $display("FAIL pg_off got %0d exp 0", ec[1]); end
        run(1, 1'b0, 1'b1, -1, cyc, bad, last);
        checks++;
        if (ec[1] !== 16'd2000 || pass[1] !== 1'b0 || fv[1] !== 1'b1) begin
            errors++;
            $display("FAIL pg_on got err=%0d pass=%0b fv=%0b exp 2000 0 1", ec[1], pass[1], fv[1]);
        end
        fault[1] = 0;
    endtask

    task automatic test_saturate();
        int cyc, bad; logic [31:0] last;
        fault[2] = 2;
        run(2, 1'b0, 1'b0, -1, cyc, bad, last);
        fault[2] = 0;
        checks++;
        if (ec[2] !== 16'd15) begin errors++; $display("FAIL sat_err_cnt got %0d exp 15", ec[2]); end
        checks++;
        if (fv[2] !== 1'b1 || fa[2] !== 8'd0 || fb[2] !== 8'd0 || fc[2] !== 1'b0) begin
            errors++;
            $display("FAIL sat_capture got fv=%0b a=%0d b=%0d cin=%0b exp 1 0 0 0", fv[2], fa[2], fb[2], fc[2]);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start[0] = 1'b1; mode[0] = 1'b0; pg[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || vc[0] !== 17'd100) begin
            errors++;
            $display("FAIL mid_run_state got busy=%0b vec_cnt=%0d exp 1 100", busy[0], vc[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b0 || vc[0] !== 17'd0 || ec[0] !== 16'd0 ||
            ao[0] !== 8'd0 || bo[0] !== 8'd0 || cin_o[0] !== 1'b0 || fv[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got busy=%0b done=%0b vec_cnt=%0d a=%0d b=%0d exp all 0",
                     busy[0], done[0], vc[0], ao[0], bo[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || vc[0] !== 17'd0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%0b done=%0b vec_cnt=%0d exp 0 0 0", busy[0], done[0], vc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_stuck_s0();
        test_restart_from_done();
        test_start_in_run();
        test_random();
        test_pg();
        test_saturate();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
